// File: rtl/vend_controller.sv
// Vending transaction controller: coin credit, purchase check, dispense timing, change payout.
// Optional VEND_AUTO_CHANGE_EN: return leftover credit automatically after a dispense.
module vend_controller #(
    parameter int PRICE_0         = 25,
    parameter int PRICE_1         = 50,
    parameter int PRICE_2         = 75,
    parameter int PRICE_3         = 100,
    parameter int MAX_CREDIT      = 200,
    parameter int CHANGE_UNIT     = 5,
    parameter int DISPENSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [7:0] coin_value,
    input  logic [1:0] item_select,
    input  logic       vend_req,
    input  logic       cancel,
    input  logic [3:0] stock_available,
    input  logic       change_ready,
    output logic       vend_pulse,
    output logic [1:0] vend_item,
    output logic       motor_on,
    output logic       change_valid,
    output logic       coin_reject,
    output logic [7:0] credit,
    output logic [1:0] error_code,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CHECK, DISPENSE, CHANGE} state_t;

    state_t      state;
    logic [1:0]  sel;
    logic [15:0] cnt;
    logic [8:0]  coin_sum;
    logic        coin_ok;
    logic [7:0]  credit_in;
    logic [7:0]  credit_less_unit;
    logic [7:0]  price;

    always_comb begin
        coin_sum         = {1'b0, credit} + {1'b0, coin_value};
        coin_ok          = coin_valid && (coin_sum <= 9'(MAX_CREDIT));
        credit_in        = coin_ok ? coin_sum[7:0] : credit;
        credit_less_unit = credit - 8'(CHANGE_UNIT);
        case (sel)
            2'd0:    price = 8'(PRICE_0);
            2'd1:    price = 8'(PRICE_1);
            2'd2:    price = 8'(PRICE_2);
            default: price = 8'(PRICE_3);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sel          <= '0;
            cnt          <= '0;
            credit       <= '0;
            error_code   <= '0;
            vend_pulse   <= 1'b0;
            vend_item    <= '0;
            motor_on     <= 1'b0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            vend_pulse  <= 1'b0;
            coin_reject <= coin_valid;
            case (state)
                IDLE: begin
                    coin_reject <= coin_valid && !coin_ok;
                    if (coin_ok) begin
                        credit     <= coin_sum[7:0];
                        error_code <= 2'd0;
                    end
                    // A same-cycle coin is folded into credit_in before the refund decision.
                    if (cancel) begin
                        state        <= CHANGE;
                        busy         <= 1'b1;
                        change_valid <= (credit_in >= 8'(CHANGE_UNIT));
                    end else if (vend_req) begin
                        sel   <= item_select;
                        state <= CHECK;
                        busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (!stock_available[sel]) begin
                        error_code <= 2'd1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else if (credit < price) begin
                        error_code <= 2'd2;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        credit     <= credit - price;
                        vend_pulse <= 1'b1;
                        vend_item  <= sel;
                        motor_on   <= 1'b1;
                        cnt        <= 16'(DISPENSE_CYCLES - 1);
                        error_code <= 2'd0;
                        state      <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (cnt == '0) begin
                        motor_on <= 1'b0;
`ifdef VEND_AUTO_CHANGE_EN
                        if (credit >= 8'(CHANGE_UNIT)) begin
                            state        <= CHANGE;
                            change_valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                CHANGE: begin
                    if (change_valid) begin
                        if (change_ready) begin
                            credit <= credit_less_unit;
                            if (credit_less_unit < 8'(CHANGE_UNIT)) begin
                                change_valid <= 1'b0;
                                state        <= IDLE;
                                busy         <= 1'b0;
                            end
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
